// File: rtl/room_thermal_if.sv
// Command/observation bundle between the air-conditioning controller (master)
// and the room thermal plant (slave).
interface room_thermal_if #(
  parameter int TEMP_W = 5
);
  logic              heating;
  logic              cooling;
  logic              load;
  logic [TEMP_W-1:0] load_temp;
  logic [TEMP_W-1:0] temperature;
  logic              fault;
  logic              saturated;

  modport master (
    output heating, cooling, load, load_temp,
    input  temperature, fault, saturated
  );

  modport slave (
    input  heating, cooling, load, load_temp,
    output temperature, fault, saturated
  );
endinterface

// File: rtl/room_thermal_model.sv
// Behavioural room thermal plant: temperature ramps at per-mode rates while heating
// or cooling, drifts toward ambient when idle, and freezes while both commands clash.
module room_thermal_model #(
  parameter int TEMP_W    = 5,
  parameter int INIT_TEMP = 20,
  parameter int AMBIENT   = 15,
  parameter int TEMP_MIN  = 0,
  parameter int TEMP_MAX  = 31,
  parameter int HEAT_DIV  = 4,
  parameter int COOL_DIV  = 4,
  parameter int DRIFT_DIV = 16
) (
  input logic            clk,
  input logic            rst_n,
  room_thermal_if.slave  thermal
);

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_HEAT  = 2'd1;
  localparam logic [1:0] MODE_COOL  = 2'd2;
  localparam logic [1:0] MODE_FAULT = 2'd3;

  localparam int DIV_HC  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
  localparam int DIV_MAX = (DIV_HC > DRIFT_DIV) ? DIV_HC : DRIFT_DIV;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_DIV - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_DIV - 1);
  localparam logic [CNT_W-1:0] DRIFT_LAST = CNT_W'(DRIFT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              fault_q, fault_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cnt_last;

  // Bound arithmetic is done in int so no comparison degenerates at full-range limits.
  function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] t);
    int ti;
    ti = int'(t);
    if (ti < TEMP_MIN) begin
      ti = TEMP_MIN;
    end else if (ti > TEMP_MAX) begin
      ti = TEMP_MAX;
    end else begin
      ti = ti;
    end
    return TEMP_W'(ti);
  endfunction

  function automatic logic [TEMP_W-1:0] step_temp(input logic [1:0] mode,
                                                  input logic [TEMP_W-1:0] t);
    int ti;
    ti = int'(t);
    case (mode)
      MODE_HEAT: begin
        if (ti < TEMP_MAX) ti = ti + 1;
        else               ti = TEMP_MAX;
      end
      MODE_COOL: begin
        if (ti > TEMP_MIN) ti = ti - 1;
        else               ti = TEMP_MIN;
      end
      MODE_IDLE: begin
        if (ti < AMBIENT)      ti = ti + 1;
        else if (ti > AMBIENT) ti = ti - 1;
        else                   ti = ti;
      end
      default: ti = ti;
    endcase
    return TEMP_W'(ti);
  endfunction

  // Decode the commanded mode and pick the terminal count of the current mode.
  always_comb begin
    mode_d   = MODE_IDLE;
    cnt_last = DRIFT_LAST;
    case ({thermal.heating, thermal.cooling})
      2'b10:   mode_d = MODE_HEAT;
      2'b01:   mode_d = MODE_COOL;
      2'b11:   mode_d = MODE_FAULT;
      default: mode_d = MODE_IDLE;
    endcase
    case (mode_q)
      MODE_HEAT: cnt_last = HEAT_LAST;
      MODE_COOL: cnt_last = COOL_LAST;
      default:   cnt_last = DRIFT_LAST;
    endcase
  end

  // Next-state: load beats a mode change, which beats a pending step.
  always_comb begin
    temp_d = temp_q;
    cnt_d  = cnt_q;
    if (thermal.load) begin
      temp_d = clamp_temp(thermal.load_temp);
      cnt_d  = CNT_ZERO;
    end else if (mode_d != mode_q) begin
      cnt_d = CNT_ZERO;
    end else if (mode_q == MODE_FAULT) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == cnt_last) begin
      temp_d = step_temp(mode_q, temp_q);
      cnt_d  = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    fault_d = (mode_d == MODE_FAULT);
    sat_d   = ((mode_d == MODE_HEAT) && (int'(temp_d) == TEMP_MAX)) ||
              ((mode_d == MODE_COOL) && (int'(temp_d) == TEMP_MIN));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      temp_q  <= TEMP_W'(INIT_TEMP);
      cnt_q   <= CNT_ZERO;
      mode_q  <= MODE_IDLE;
      fault_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      temp_q  <= temp_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fault_q <= fault_d;
      sat_q   <= sat_d;
    end
  end

  assign thermal.temperature = temp_q;
  assign thermal.fault       = fault_q;
  assign thermal.saturated   = sat_q;

endmodule

// File: tb/tb_room_thermal_model.sv
// Directed bench for room_thermal_model with hand-computed expected temperatures.
module tb_room_thermal_model;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   err_cnt;

  room_thermal_if #(.TEMP_W(5)) thermal_if ();

  room_thermal_model dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .thermal (thermal_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    chk_cnt++;
    if (obs != exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    thermal_if.heating   = 1'b0;
    thermal_if.cooling   = 1'b0;
    thermal_if.load      = 1'b0;
    thermal_if.load_temp = 5'd0;

    // reset state
    tick(2);
    check_eq("rst_temp", int'(thermal_if.temperature), 20);
    check_eq("rst_fault", int'(thermal_if.fault), 0);
    check_eq("rst_sat", int'(thermal_if.saturated), 0);
    rst_n = 1'b1;

    // idle drift from 20 toward 15
    tick(15);
    check_eq("drift_pre", int'(thermal_if.temperature), 20);
    tick(1);
    check_eq("drift_16", int'(thermal_if.temperature), 19);
    tick(64);
    check_eq("drift_80", int'(thermal_if.temperature), 15);
    tick(20);
    check_eq("drift_hold", int'(thermal_if.temperature), 15);

    // heating ramp from 20
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    thermal_if.heating = 1'b1;
    tick(1);
    tick(3);
    check_eq("heat_pre", int'(thermal_if.temperature), 20);
    tick(1);
    check_eq("heat_4", int'(thermal_if.temperature), 21);
    tick(4);
    check_eq("heat_8", int'(thermal_if.temperature), 22);
    tick(4);
    check_eq("heat_12", int'(thermal_if.temperature), 23);
    check_eq("heat_sat", int'(thermal_if.saturated), 0);

    // reset mid-ramp at cnt=2
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_eq("midrst_temp", int'(thermal_if.temperature), 20);
    rst_n = 1'b1;
    tick(1);
    tick(3);
    check_eq("midrst_pre", int'(thermal_if.temperature), 20);
    tick(1);
    check_eq("midrst_step", int'(thermal_if.temperature), 21);

    // load 30 then heat into the upper bound
    thermal_if.heating   = 1'b0;
    thermal_if.load      = 1'b1;
    thermal_if.load_temp = 5'd30;
    tick(1);
    check_eq("load30", int'(thermal_if.temperature), 30);
    thermal_if.load    = 1'b0;
    thermal_if.heating = 1'b1;
    tick(4);
    check_eq("top_pre", int'(thermal_if.temperature), 30);
    tick(1);
    check_eq("top_31", int'(thermal_if.temperature), 31);
    check_eq("top_sat", int'(thermal_if.saturated), 1);
    tick(20);
    check_eq("top_hold", int'(thermal_if.temperature), 31);
    check_eq("top_sat_hold", int'(thermal_if.saturated), 1);
    thermal_if.heating = 1'b0;
    thermal_if.cooling = 1'b1;
    tick(1);
    check_eq("cool_sat_clr", int'(thermal_if.saturated), 0);
    tick(3);
    check_eq("cool_pre", int'(thermal_if.temperature), 31);
    tick(1);
    check_eq("cool_30", int'(thermal_if.temperature), 30);

    // load 10 then idle drift upward
    thermal_if.cooling   = 1'b0;
    thermal_if.load      = 1'b1;
    thermal_if.load_temp = 5'd10;
    tick(1);
    check_eq("load10", int'(thermal_if.temperature), 10);
    thermal_if.load = 1'b0;
    tick(15);
    check_eq("up_pre", int'(thermal_if.temperature), 10);
    tick(1);
    check_eq("up_11", int'(thermal_if.temperature), 11);

    // conflicting commands freeze the plant
    thermal_if.heating = 1'b1;
    thermal_if.cooling = 1'b1;
    tick(1);
    check_eq("fault_set", int'(thermal_if.fault), 1);
    tick(10);
    check_eq("fault_frozen", int'(thermal_if.temperature), 11);
    check_eq("fault_hold", int'(thermal_if.fault), 1);
    thermal_if.heating = 1'b0;
    thermal_if.cooling = 1'b0;
    tick(1);
    check_eq("fault_clr", int'(thermal_if.fault), 0);
    tick(15);
    check_eq("postfault_pre", int'(thermal_if.temperature), 11);
    tick(1);
    check_eq("postfault_12", int'(thermal_if.temperature), 12);

    // toggling heating faster than any divider never steps
    for (int i = 0; i < 8; i++) begin
      thermal_if.heating = ~thermal_if.heating;
      tick(3);
    end
    check_eq("toggle_hold", int'(thermal_if.temperature), 12);

    // cooling into the lower bound, no wrap
    thermal_if.heating   = 1'b0;
    thermal_if.cooling   = 1'b1;
    thermal_if.load      = 1'b1;
    thermal_if.load_temp = 5'd1;
    tick(1);
    check_eq("load1", int'(thermal_if.temperature), 1);
    check_eq("load1_sat", int'(thermal_if.saturated), 0);
    thermal_if.load = 1'b0;
    tick(3);
    check_eq("bot_pre", int'(thermal_if.temperature), 1);
    tick(1);
    check_eq("bot_0", int'(thermal_if.temperature), 0);
    check_eq("bot_sat", int'(thermal_if.saturated), 1);
    tick(8);
    check_eq("bot_hold", int'(thermal_if.temperature), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
